// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared time-of-day limits, field widths, the hh:mm:ss record
//               type and a legality check for front-panel set values.
//               Used by the timebase, the display driver and the set-time
//               logic.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } tod_t;

    // True when a requested hour/minute pair is a real time of day.
    function automatic logic set_is_legal(input logic [HOUR_W-1:0] h,
                                          input logic [MIN_W-1:0]  m);
        return (h <= HOUR_W'(HOUR_MAX)) && (m <= MIN_W'(MIN_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_timebase_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_timebase_if
// Description : Bundle between the front panel / display side (master) and
//               the timebase (slave).
//   master drives : speed_up, set_en, set_hour, set_min
//   slave drives  : tick, sec, min, hour, day_wrap, set_err
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_timebase_if;
    import clock_pkg::*;

    logic              speed_up;
    logic              set_en;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_min;
    logic              tick;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic              day_wrap;
    logic              set_err;

    modport master (
        output speed_up, set_en, set_hour, set_min,
        input  tick, sec, min, hour, day_wrap, set_err
    );

    modport slave (
        input  speed_up, set_en, set_hour, set_min,
        output tick, sec, min, hour, day_wrap, set_err
    );

endinterface
`default_nettype wire

// File: rtl/clock_timebase_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk into a one-cycle tick. The divisor is picked
//               every cycle from speed_up_i, so a rate change takes effect
//               on the running count without clearing it.
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   speed_up_i in  1 = fast divisor
//   restart_i  in  clear the count and suppress tick (period restart)
//   tick_o     out registered one-cycle tick
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int FAST_FACTOR = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic speed_up_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int NORM_DIV = CLK_HZ;
    localparam int FAST_DIV = CLK_HZ / FAST_FACTOR;
    localparam int CNT_W    = $clog2(NORM_DIV);

    localparam logic [CNT_W-1:0] C_NORM_LAST = CNT_W'(NORM_DIV - 1);
    localparam logic [CNT_W-1:0] C_FAST_LAST = CNT_W'(FAST_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_w;
    logic             tick_q, tick_d;

    always_comb begin
        last_w = speed_up_i ? C_FAST_LAST : C_NORM_LAST;
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q >= last_w) begin
            // ">=" so that a switch to the fast rate with the count already
            // past the fast terminal value fires immediately.
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: rtl/clock_timebase.sv
`default_nettype none
// ============================================================================
// Module      : clock_timebase
// Description : Seconds timebase and 24 h hh:mm:ss counter with front-panel
//               hour/minute load. All outputs are registered.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   bus   slave side of clock_timebase_if
//         in : speed_up, set_en, set_hour, set_min
//         out: tick, sec, min, hour, day_wrap, set_err
// Revision    : 1.0 - initial release
// ============================================================================
module clock_timebase
    import clock_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int FAST_FACTOR = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    clock_timebase_if.slave  bus
);

    logic tick_w;
    logic set_ok_w;
    tod_t tod_q, tod_d;
    logic day_wrap_q, day_wrap_d;
    logic set_err_q, set_err_d;

    assign set_ok_w = bus.set_en && set_is_legal(bus.set_hour, bus.set_min);

    // A valid load also restarts the seconds period.
    tick_prescaler #(
        .CLK_HZ      (CLK_HZ),
        .FAST_FACTOR (FAST_FACTOR)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .speed_up_i (bus.speed_up),
        .restart_i  (set_ok_w),
        .tick_o     (tick_w)
    );

    always_comb begin
        tod_d      = tod_q;
        day_wrap_d = 1'b0;
        set_err_d  = bus.set_en && !set_ok_w;
        if (set_ok_w) begin
            // A valid load wins over a coincident increment.
            tod_d.hour = bus.set_hour;
            tod_d.min  = bus.set_min;
            tod_d.sec  = '0;
        end else if (tick_w) begin
            if (tod_q.sec == SEC_W'(SEC_MAX)) begin
                tod_d.sec = '0;
                if (tod_q.min == MIN_W'(MIN_MAX)) begin
                    tod_d.min = '0;
                    if (tod_q.hour == HOUR_W'(HOUR_MAX)) begin
                        tod_d.hour = '0;
                        day_wrap_d = 1'b1;
                    end else begin
                        tod_d.hour = tod_q.hour + HOUR_W'(1);
                    end
                end else begin
                    tod_d.min = tod_q.min + MIN_W'(1);
                end
            end else begin
                tod_d.sec = tod_q.sec + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tod_q      <= '0;
            day_wrap_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            tod_q      <= tod_d;
            day_wrap_q <= day_wrap_d;
            set_err_q  <= set_err_d;
        end
    end

    assign bus.tick     = tick_w;
    assign bus.sec      = tod_q.sec;
    assign bus.min      = tod_q.min;
    assign bus.hour     = tod_q.hour;
    assign bus.day_wrap = day_wrap_q;
    assign bus.set_err  = set_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_timebase.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_timebase
// Description : Self-checking bench for clock_timebase with CLK_HZ=12,
//               FAST_FACTOR=4 (periods of 12 and 3 cycles). A reference
//               model keeps time as seconds-of-day and is compared with the
//               DUT every cycle; directed literal checks pin key cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_timebase;
    import clock_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_timebase_if bus ();

    clock_timebase #(
        .CLK_HZ      (12),
        .FAST_FACTOR (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    int   m_cnt;    // cycles elapsed in the current period
    int   m_tod;    // seconds since midnight
    logic m_tick, m_wrap, m_err;
    logic m_legal;
    int   m_last;

    assign m_legal = bus.set_en && (int'(bus.set_hour) <= 23) && (int'(bus.set_min) <= 59);
    assign m_last  = bus.speed_up ? 2 : 11;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_tod  <= 0;
            m_tick <= 1'b0;
            m_wrap <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_err  <= bus.set_en && !m_legal;
            m_wrap <= !m_legal && m_tick && (m_tod == 86399);
            m_tod  <= m_legal ? (int'(bus.set_hour) * 3600 + int'(bus.set_min) * 60)
                    : m_tick  ? (m_tod + 1) % 86400 : m_tod;
            m_tick <= !m_legal && (m_cnt >= m_last);
            m_cnt  <= (m_legal || m_cnt >= m_last) ? 0 : m_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int k      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
        check("model_tick",     32'(bus.tick),     32'(m_tick));
        check("model_sec",      32'(bus.sec),      32'(m_tod % 60));
        check("model_min",      32'(bus.min),      32'((m_tod / 60) % 60));
        check("model_hour",     32'(bus.hour),     32'(m_tod / 3600));
        check("model_day_wrap", 32'(bus.day_wrap), 32'(m_wrap));
        check("model_set_err",  32'(bus.set_err),  32'(m_err));
    endtask

    task automatic do_set(input int h, input int m);
        bus.set_en   = 1'b1;
        bus.set_hour = 5'(h);
        bus.set_min  = 6'(m);
        step();
        bus.set_en   = 1'b0;
    endtask

    initial begin
        int w;
        bus.speed_up = 1'b0;
        bus.set_en   = 1'b0;
        bus.set_hour = '0;
        bus.set_min  = '0;

        // Reset state
        repeat (3) step();
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_sec",  32'(bus.sec),  0);
        check("rst_hour", 32'(bus.hour), 0);

        // Normal rate after release: ticks at 12, 24, 36
        rst_n = 1'b1;
        k = 0;
        repeat (36) begin
            step();
            if (k == 11) check("p1_no_tick_11", 32'(bus.tick), 0);
            if (k == 12 || k == 24 || k == 36) check("p1_tick", 32'(bus.tick), 1);
            if (k == 13) check("p1_sec_after_first", 32'(bus.sec), 1);
        end

        // Fast rate entered with cnt=7, then back to normal
        while (k < 75) begin
            step();
            if (k == 44 || k == 47 || k == 50 || k == 62 || k == 74)
                check("p2_tick", 32'(bus.tick), 1);
            if (k == 53) check("p2_no_tick_53", 32'(bus.tick), 0);
            if (k == 43) bus.speed_up = 1'b1;
            if (k == 52) bus.speed_up = 1'b0;
        end

        // Load 23:59, 60 ticks later the day wraps
        do_set(23, 59);
        check("p3_hour", 32'(bus.hour), 23);
        check("p3_min",  32'(bus.min),  59);
        check("p3_sec",  32'(bus.sec),  0);
        repeat (721) step();
        check("p3_wrap_hour", 32'(bus.hour), 0);
        check("p3_wrap_min",  32'(bus.min),  0);
        check("p3_wrap_sec",  32'(bus.sec),  0);
        check("p3_day_wrap",  32'(bus.day_wrap), 1);
        step();
        check("p3_day_wrap_drop", 32'(bus.day_wrap), 0);

        // Illegal loads rejected
        do_set(24, 10);
        check("p4_err_hour", 32'(bus.set_err), 1);
        check("p4_keep_hour", 32'(bus.hour), 0);
        step();
        check("p4_err_drop", 32'(bus.set_err), 0);
        do_set(5, 60);
        check("p4_err_min", 32'(bus.set_err), 1);
        check("p4_keep_min", 32'(bus.min), 0);

        // Load coincident with a tick
        w = 0;
        do begin
            step();
            w++;
        end while (bus.tick !== 1'b1 && w < 20);
        check("p5_tick_wait", 32'(bus.tick), 1);
        do_set(12, 34);
        check("p5_hour", 32'(bus.hour), 12);
        check("p5_min",  32'(bus.min),  34);
        check("p5_sec",  32'(bus.sec),  0);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 11) check("p5_no_tick_11", 32'(bus.tick), 0);
            if (i == 12) check("p5_tick_12",    32'(bus.tick), 1);
        end

        // Reach 12:34:56, then reset mid-period
        repeat (661) step();
        repeat (5) step();
        check("p6_hour", 32'(bus.hour), 12);
        check("p6_min",  32'(bus.min),  34);
        check("p6_sec",  32'(bus.sec),  56);
        #2 rst_n = 1'b0;
        #1;
        check("p6_async_sec",  32'(bus.sec),  0);
        check("p6_async_min",  32'(bus.min),  0);
        check("p6_async_hour", 32'(bus.hour), 0);
        check("p6_async_tick", 32'(bus.tick), 0);
        check("p6_async_err",  32'(bus.set_err), 0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i < 12) check("p6_quiet_tick", 32'(bus.tick), 0);
            if (i == 12) check("p6_first_tick", 32'(bus.tick), 1);
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
